// File: rtl/keccak_round_ctrl.sv
// Sequencing controller for the Keccak-f[1600] accelerator: load, round steps, store,
// plus state-memory arbitration between the bus and the datapath and sticky status flags.
module keccak_round_ctrl #(
  parameter int unsigned NUM_ROUNDS       = 24,
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter int unsigned IDX_W            = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             done_clr_i,
  input  logic             intr_en_i,
  input  logic             bus_req_i,
  output logic             bus_gnt_o,
  output logic             dp_load_o,
  output logic             dp_round_en_o,
  output logic [IDX_W-1:0] dp_round_idx_o,
  output logic             dp_store_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             start_err_o,
  output logic             intr_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StRound, StStore} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_ROUNDS - ROUNDS_PER_CYCLE);
  localparam logic [IDX_W-1:0] Step    = IDX_W'(ROUNDS_PER_CYCLE);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             intr_q, intr_d;
  logic             finish;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StLoad;
      end
      StLoad: begin
        state_d = StRound;
        cnt_d   = '0;
      end
      StRound: begin
        if (cnt_q == LastIdx) begin
          state_d = StStore;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + Step;
        end
      end
      StStore: begin
        state_d = StIdle;
        finish  = 1'b1;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    // Abort overrides every transition, including completion from STORE.
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = '0;
      finish  = 1'b0;
    end
  end

  // Set events are applied after the clear so they win when coincident.
  always_comb begin
    done_d = done_q;
    err_d  = err_q;
    if (done_clr_i) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (finish) done_d = 1'b1;
    if (start_i && (state_q != StIdle)) err_d = 1'b1;
    intr_d = finish & intr_en_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      intr_q  <= intr_d;
    end
  end

  assign bus_gnt_o      = bus_req_i && (state_q == StIdle);
  assign dp_load_o      = (state_q == StLoad);
  assign dp_round_en_o  = (state_q == StRound);
  assign dp_round_idx_o = (state_q == StRound) ? cnt_q : '0;
  assign dp_store_o     = (state_q == StStore);
  assign busy_o         = (state_q != StIdle);
  assign done_o         = done_q;
  assign start_err_o    = err_q;
  assign intr_o         = intr_q;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Scoreboard bench for keccak_round_ctrl: stimulus queues expected datapath/interrupt events,
// a negedge monitor pops and compares them; status flags are checked inline.
module tb_keccak_round_ctrl;

  localparam int unsigned IdxW = 5;

  logic clk = 1'b0;
  logic rst, start, abort, done_clr, intr_en, bus_req, start4;
  logic bus_gnt, dp_load, dp_round_en, dp_store, busy, done, start_err, intr;
  logic [IdxW-1:0] dp_round_idx;
  logic bus_gnt4, dp_load4, dp_round_en4, dp_store4, busy4, done4, start_err4, intr4;
  logic [IdxW-1:0] dp_round_idx4;

  always #5 clk = ~clk;

  keccak_round_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .done_clr_i(done_clr),
    .intr_en_i(intr_en), .bus_req_i(bus_req), .bus_gnt_o(bus_gnt), .dp_load_o(dp_load),
    .dp_round_en_o(dp_round_en), .dp_round_idx_o(dp_round_idx), .dp_store_o(dp_store),
    .busy_o(busy), .done_o(done), .start_err_o(start_err), .intr_o(intr)
  );

  keccak_round_ctrl #(.NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(4), .IDX_W(IdxW)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .abort_i(1'b0), .done_clr_i(1'b0),
    .intr_en_i(intr_en), .bus_req_i(1'b0), .bus_gnt_o(bus_gnt4), .dp_load_o(dp_load4),
    .dp_round_en_o(dp_round_en4), .dp_round_idx_o(dp_round_idx4), .dp_store_o(dp_store4),
    .busy_o(busy4), .done_o(done4), .start_err_o(start_err4), .intr_o(intr4)
  );

  typedef enum int {EvLoad, EvRound, EvStore, EvIntr} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cyc;
    int       idx;
  } ev_t;

  ev_t exp_q[$];
  ev_t exp4_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic match(input bit sel, input ev_kind_e k, input int idx);
    ev_t e;
    checks++;
    if ((sel ? exp4_q.size() : exp_q.size()) == 0) begin
      failures++;
      $display("FAIL unexpected_event dut%0d: got %s idx=%0d at cycle %0d, required none",
               sel ? 4 : 1, k.name(), idx, cyc);
      return;
    end
    if (sel) e = exp4_q.pop_front();
    else e = exp_q.pop_front();
    if (e.kind != k || e.cyc != cyc || e.idx != idx) begin
      failures++;
      $display("FAIL event dut%0d: got %s idx=%0d cycle=%0d, required %s idx=%0d cycle=%0d",
               sel ? 4 : 1, k.name(), idx, cyc, e.kind.name(), e.idx, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dp_load)      match(1'b0, EvLoad, 0);
      if (dp_round_en)  match(1'b0, EvRound, int'(dp_round_idx));
      if (dp_store)     match(1'b0, EvStore, 0);
      if (intr)         match(1'b0, EvIntr, 0);
      if (dp_load4)     match(1'b1, EvLoad, 0);
      if (dp_round_en4) match(1'b1, EvRound, int'(dp_round_idx4));
      if (dp_store4)    match(1'b1, EvStore, 0);
      if (intr4)        match(1'b1, EvIntr, 0);
    end
  end

  task automatic push_ev(input bit sel, input ev_kind_e k, input int c, input int idx);
    ev_t e;
    e = '{kind: k, cyc: c, idx: idx};
    if (sel) exp4_q.push_back(e);
    else exp_q.push_back(e);
  endtask

  // Start sampled at the end of cycle c0: LOAD at c0+1, round step s at c0+2+s.
  task automatic push_run(input bit sel, input int c0, input int rpc, input int steps,
                          input bit full, input bit irq);
    push_ev(sel, EvLoad, c0 + 1, 0);
    for (int s = 0; s < steps; s++) push_ev(sel, EvRound, c0 + 2 + s, s * rpc);
    if (full) push_ev(sel, EvStore, c0 + 2 + steps, 0);
    if (full && irq) push_ev(sel, EvIntr, c0 + 3 + steps, 0);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_idx(input string name, input logic [IdxW-1:0] act,
                         input logic [IdxW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) next();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1, c2, c3, c4, c5;
    rst = 1'b0; start = 1'b0; abort = 1'b0; done_clr = 1'b0;
    intr_en = 1'b0; bus_req = 1'b1; start4 = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk1("reset_gnt_follows_req", bus_gnt, 1'b1);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_err", start_err, 1'b0);
    chk1("reset_load", dp_load, 1'b0);
    chk1("reset_round_en", dp_round_en, 1'b0);
    chk_idx("reset_idx", dp_round_idx, '0);
    next();
    rst = 1'b0;

    // Default run on both instances with the bus held across start.
    next();
    intr_en = 1'b1; start = 1'b1; start4 = 1'b1; c0 = cyc;
    push_run(1'b0, c0, 1, 24, 1'b1, 1'b1);
    push_run(1'b1, c0, 4, 6, 1'b1, 1'b1);
    #1;
    chk1("gnt_start_cycle", bus_gnt, 1'b1);
    for (int k = 1; k <= 27; k++) begin
      next();
      start = 1'b0; start4 = 1'b0;
      #1;
      chk1("gnt_stall", bus_gnt, k == 27);
      chk1("busy", busy, k < 27);
      chk1("done_timing", done, k == 27);
      if (k == 1 || k == 26) chk_idx("idx_zero_outside_round", dp_round_idx, '0);
      if (k == 8 || k == 9) chk1("done4_timing", done4, k == 9);
    end
    bus_req = 1'b0;

    // Start while busy at idx 10, then clear both sticky flags.
    next();
    start = 1'b1; c1 = cyc;
    push_run(1'b0, c1, 1, 24, 1'b1, 1'b1);
    next();
    start = 1'b0;
    chk1("done_kept_on_start", done, 1'b1);
    run_to(c1 + 12);
    chk_idx("idx_before_restart", dp_round_idx, 5'd10);
    start = 1'b1;
    next();
    start = 1'b0;
    chk1("start_err_set", start_err, 1'b1);
    chk1("busy_after_restart", busy, 1'b1);
    run_to(c1 + 27);
    chk1("done_after_restart", done, 1'b1);
    done_clr = 1'b1;
    next();
    done_clr = 1'b0;
    chk1("done_cleared", done, 1'b0);
    chk1("err_cleared", start_err, 1'b0);

    // Abort at idx 5.
    next();
    start = 1'b1; c2 = cyc;
    push_run(1'b0, c2, 1, 6, 1'b0, 1'b0);
    next();
    start = 1'b0;
    run_to(c2 + 7);
    abort = 1'b1;
    next();
    abort = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_store", dp_store, 1'b0);
    for (int k = 0; k < 22; k++) begin
      chk1("abort_no_done", done, 1'b0);
      next();
    end

    // Abort together with start in IDLE: start wins and completes.
    start = 1'b1; abort = 1'b1; c3 = cyc;
    push_run(1'b0, c3, 1, 24, 1'b1, 1'b1);
    next();
    start = 1'b0; abort = 1'b0;
    chk1("abort_start_busy", busy, 1'b1);
    run_to(c3 + 27);
    chk1("abort_start_done", done, 1'b1);
    done_clr = 1'b1;
    next();
    done_clr = 1'b0;
    chk1("done_cleared_2", done, 1'b0);

    // Clear coinciding with set, interrupts disabled.
    intr_en = 1'b0;
    next();
    start = 1'b1; c4 = cyc;
    push_run(1'b0, c4, 1, 24, 1'b1, 1'b0);
    next();
    start = 1'b0;
    run_to(c4 + 26);
    chk1("store_cycle", dp_store, 1'b1);
    done_clr = 1'b1;
    next();
    done_clr = 1'b0;
    chk1("set_wins_over_clr", done, 1'b1);
    chk1("intr_gated", intr, 1'b0);

    // Reset mid-ROUND with sticky flags set.
    intr_en = 1'b1;
    next();
    start = 1'b1; c5 = cyc;
    push_run(1'b0, c5, 1, 8, 1'b0, 1'b0);
    next();
    start = 1'b0;
    run_to(c5 + 5);
    start = 1'b1;
    next();
    start = 1'b0;
    chk1("err_before_reset", start_err, 1'b1);
    run_to(c5 + 10);
    #2 rst = 1'b1;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", start_err, 1'b0);
    chk1("rst_round_en", dp_round_en, 1'b0);
    chk_idx("rst_idx", dp_round_idx, '0);
    chk1("rst_intr", intr, 1'b0);
    chk1("rst_gnt", bus_gnt, 1'b0);
    next();
    rst = 1'b0;
    repeat (3) next();
    chk1("idle_after_reset", busy, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events dut1: got %0d pending, required 0", exp_q.size());
    end
    checks++;
    if (exp4_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events dut4: got %0d pending, required 0", exp4_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
